// File: rtl/sobel_window_controller_if.sv
// Pixel-stream in / 3x3-window out bundle of the Sobel window sequencer.
// The controller sits on the slave side; the pixel source and the gradient
// result stage together form the master side.
interface sobel_window_controller_if #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);

    logic             frame_start;
    logic [7:0]       pixel_in;
    logic             pixel_valid;
    logic             pixel_ready;
    logic [7:0]       windowBuffer [0:8];
    logic             start_calculations;
    logic             calc_ack;
    logic [ROW_W-1:0] win_row;
    logic [COL_W-1:0] win_col;
    logic             busy;
    logic             frame_done;

    modport master (
        output frame_start, pixel_in, pixel_valid, calc_ack,
        input  pixel_ready, windowBuffer, start_calculations,
               win_row, win_col, busy, frame_done
    );

    modport slave (
        input  frame_start, pixel_in, pixel_valid, calc_ack,
        output pixel_ready, windowBuffer, start_calculations,
               win_row, win_col, busy, frame_done
    );
endinterface

// File: rtl/sobel_window_controller.sv
// Sobel window sequencer: accepts raster-order pixels, keeps two line
// buffers and a 3x3 shift window, and qualifies every fully populated
// window with start_calculations until the result stage acknowledges it.
module sobel_window_controller #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input logic                      clk,
    input logic                      rst,
    sobel_window_controller_if.slave bus
);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] col_r;
    logic [7:0]       lb_top_r [0:IMG_WIDTH-1];
    logic [7:0]       lb_mid_r [0:IMG_WIDTH-1];
    logic [7:0]       win_r    [0:8];
    logic             start_r;
    logic [ROW_W-1:0] win_row_r;
    logic [COL_W-1:0] win_col_r;
    logic             busy_r;
    logic             frame_done_r;

    logic             ready_s;
    logic             accept_s;
    logic             last_pixel_s;
    logic             window_valid_s;
    logic             consume_s;

    // Handshake decode: a pixel may enter only while streaming and the
    // current window is either absent or being consumed this very cycle.
    always_comb begin
        ready_s        = 1'b0;
        accept_s       = 1'b0;
        last_pixel_s   = 1'b0;
        window_valid_s = 1'b0;
        consume_s      = start_r && bus.calc_ack;
        if (state_r == STREAM) begin
            ready_s = !start_r || bus.calc_ack;
        end else begin
            ready_s = 1'b0;
        end
        accept_s       = ready_s && bus.pixel_valid;
        last_pixel_s   = accept_s && (row_r == ROW_LAST) && (col_r == COL_LAST);
        // Windows whose left columns belong to the previous row (c < 2) or
        // whose top rows are not yet filled (r < 2) are never presented.
        window_valid_s = accept_s && (row_r >= ROW_TWO) && (col_r >= COL_TWO);
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.frame_start) begin
                    state_next_s = STREAM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            STREAM: begin
                if (last_pixel_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = STREAM;
                end
            end
            DONE: begin
                if (consume_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register; busy is registered from the next state so it
    // tracks STREAM/DONE without a decode on the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r <= '0;
            col_r <= '0;
        end else if ((state_r == IDLE) && bus.frame_start) begin
            row_r <= '0;
            col_r <= '0;
        end else if (accept_s) begin
            if (col_r == COL_LAST) begin
                col_r <= '0;
                if (row_r == ROW_LAST) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + ROW_W'(1);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Line buffers: the middle row ages into the top row as each new
    // pixel lands in the middle buffer at its own column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IMG_WIDTH; i++) begin
                lb_top_r[i] <= 8'd0;
                lb_mid_r[i] <= 8'd0;
            end
        end else if (accept_s) begin
            lb_top_r[col_r] <= lb_mid_r[col_r];
            lb_mid_r[col_r] <= bus.pixel_in;
        end
    end

    // 3x3 shift window: columns move left, the new right column comes from
    // the two line buffers and the incoming pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                win_r[k] <= 8'd0;
            end
        end else if (accept_s) begin
            win_r[0] <= win_r[1];
            win_r[1] <= win_r[2];
            win_r[2] <= lb_top_r[col_r];
            win_r[3] <= win_r[4];
            win_r[4] <= win_r[5];
            win_r[5] <= lb_mid_r[col_r];
            win_r[6] <= win_r[7];
            win_r[7] <= win_r[8];
            win_r[8] <= bus.pixel_in;
        end
    end

    // Window qualifier and centre coordinates; a fresh window formed in the
    // same cycle as an acknowledge keeps the qualifier high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_r   <= 1'b0;
            win_row_r <= '0;
            win_col_r <= '0;
        end else if (window_valid_s) begin
            start_r   <= 1'b1;
            win_row_r <= row_r - ROW_W'(1);
            win_col_r <= col_r - COL_W'(1);
        end else if (consume_s) begin
            start_r   <= 1'b0;
        end
    end

    // End-of-frame pulse, raised in the first IDLE cycle after the last ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= (state_r == DONE) && consume_s;
        end
    end

    assign bus.pixel_ready        = ready_s;
    assign bus.start_calculations = start_r;
    assign bus.win_row            = win_row_r;
    assign bus.win_col            = win_col_r;
    assign bus.busy               = busy_r;
    assign bus.frame_done         = frame_done_r;

    for (genvar k = 0; k < 9; k++) begin : g_win_out
        assign bus.windowBuffer[k] = win_r[k];
    end
endmodule

// File: tb/tb_sobel_window_controller.sv
// Bench for sobel_window_controller: a 4x4 instance exercises reset,
// first window, frame end, backpressure and aborted frames; an 8x8
// instance streams a random image with random valid/ack gaps.
module tb_sobel_window_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sobel_window_controller_if #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) b4();
    sobel_window_controller_if #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) b8();

    sobel_window_controller #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    sobel_window_controller #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    typedef struct packed {
        logic [71:0] w;
        int          row;
        int          col;
    } exp_win_t;

    typedef struct packed {
        int         r;
        int         c;
        logic       exp_start;
        int         exp_row;
        int         exp_col;
    } vec_t;

    exp_win_t   q4[$];
    exp_win_t   q8[$];
    exp_win_t   e4, e8;
    vec_t       vec [0:15];
    logic [7:0] img8 [0:7][0:7];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         pops4 = 0, pops8 = 0, fd4 = 0;
    logic       done8 = 1'b0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] p4(input int r, input int c);
        return 8'(16 * r + c);
    endfunction

    function automatic logic [71:0] win4(input int cr, input int cc);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = p4(cr - 1 + i, cc - 1 + j);
        return w;
    endfunction

    function automatic logic [71:0] win8(input int cr, input int cc);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = img8[cr - 1 + i][cc - 1 + j];
        return w;
    endfunction

    function automatic logic [71:0] pack9(input int a0, input int a1, input int a2, input int a3,
                                          input int a4, input int a5, input int a6, input int a7,
                                          input int a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [71:0] dut_win4();
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[8*k +: 8] = b4.windowBuffer[k];
        return w;
    endfunction

    function automatic logic [71:0] dut_win8();
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[8*k +: 8] = b8.windowBuffer[k];
        return w;
    endfunction

    function automatic int gx_of(input logic [71:0] w);
        return (int'(w[23:16]) + 2 * int'(w[47:40]) + int'(w[71:64]))
             - (int'(w[7:0])   + 2 * int'(w[31:24]) + int'(w[55:48]));
    endfunction

    task automatic check_zero4(input string tag);
        check({tag, "_window"}, dut_win4(), 72'd0);
        check({tag, "_start"},  72'(b4.start_calculations), 72'd0);
        check({tag, "_ready"},  72'(b4.pixel_ready), 72'd0);
        check({tag, "_row"},    72'(b4.win_row), 72'd0);
        check({tag, "_col"},    72'(b4.win_col), 72'd0);
        check({tag, "_busy"},   72'(b4.busy), 72'd0);
        check({tag, "_done"},   72'(b4.frame_done), 72'd0);
    endtask

    // Offer one pixel to the 4x4 instance; call just after a rising edge.
    task automatic send4(input int r, input int c, output int waited);
        int n;
        exp_win_t e;
        n = 0;
        b4.pixel_in    = p4(r, c);
        b4.pixel_valid = 1'b1;
        @(negedge clk);
        while (b4.pixel_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (b4.pixel_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send4_timeout: pixel (%0d,%0d) never accepted", r, c);
        end else begin
            @(posedge clk);
            if (r >= 2 && c >= 2) begin
                e.w = win4(r - 1, c - 1);
                e.row = r - 1;
                e.col = c - 1;
                q4.push_back(e);
            end
            #1;
        end
        b4.pixel_valid = 1'b0;
    endtask

    task automatic send8(input int r, input int c);
        int n;
        exp_win_t e;
        n = 0;
        b8.pixel_in    = img8[r][c];
        b8.pixel_valid = 1'b1;
        @(negedge clk);
        while (b8.pixel_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (b8.pixel_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send8_timeout: pixel (%0d,%0d) never accepted", r, c);
        end else begin
            @(posedge clk);
            if (r >= 2 && c >= 2) begin
                e.w = win8(r - 1, c - 1);
                e.row = r - 1;
                e.col = c - 1;
                q8.push_back(e);
            end
            #1;
        end
        b8.pixel_valid = 1'b0;
    endtask

    task automatic start4();
        b4.frame_start = 1'b1;
        @(posedge clk);
        #1;
        b4.frame_start = 1'b0;
    endtask

    // Scoreboard for the 4x4 instance: each acknowledged window is compared
    // against the oldest expectation; frame_done pulses are counted.
    always @(negedge clk) begin
        if (rst === 1'b0 && b4.start_calculations === 1'b1 && b4.calc_ack === 1'b1) begin
            pops4++;
            if (q4.size() == 0) begin
                n_fail++;
                $display("FAIL win4_unexpected: window at (%0d,%0d) with none expected", b4.win_row, b4.win_col);
            end else begin
                e4 = q4.pop_front();
                check($sformatf("win4_data_%0d_%0d", e4.row, e4.col), dut_win4(), e4.w);
                check($sformatf("win4_row_%0d_%0d", e4.row, e4.col), 72'(b4.win_row), 72'(e4.row));
                check($sformatf("win4_col_%0d_%0d", e4.row, e4.col), 72'(b4.win_col), 72'(e4.col));
            end
        end
        if (b4.frame_done === 1'b1) fd4++;
    end

    // Scoreboard for the 8x8 instance.
    always @(negedge clk) begin
        if (rst === 1'b0 && b8.start_calculations === 1'b1 && b8.calc_ack === 1'b1) begin
            pops8++;
            if (q8.size() == 0) begin
                n_fail++;
                $display("FAIL win8_unexpected: window at (%0d,%0d) with none expected", b8.win_row, b8.win_col);
            end else begin
                e8 = q8.pop_front();
                check($sformatf("win8_data_%0d_%0d", e8.row, e8.col), dut_win8(), e8.w);
                check($sformatf("win8_row_%0d_%0d", e8.row, e8.col), 72'(b8.win_row), 72'(e8.row));
                check($sformatf("win8_col_%0d_%0d", e8.row, e8.col), 72'(b8.win_col), 72'(e8.col));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int fd_before;
        int pops_before;
        int n;
        logic [71:0] first_win;
        logic [71:0] second_win;

        first_win  = pack9(0, 1, 2, 16, 17, 18, 32, 33, 34);
        second_win = pack9(1, 2, 3, 17, 18, 19, 33, 34, 35);

        b4.frame_start = 1'b0; b4.pixel_in = 8'd0; b4.pixel_valid = 1'b0; b4.calc_ack = 1'b0;
        b8.frame_start = 1'b0; b8.pixel_in = 8'd0; b8.pixel_valid = 1'b0; b8.calc_ack = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            vec[i].r         = i / 4;
            vec[i].c         = i % 4;
            vec[i].exp_start = (i / 4 >= 2) && (i % 4 >= 2);
            vec[i].exp_row   = i / 4 - 1;
            vec[i].exp_col   = i % 4 - 1;
        end

        // Reset state and idle behaviour.
        repeat (2) @(posedge clk);
        #1;
        check_zero4("reset");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("ready_idle_%0d", k), 72'(b4.pixel_ready), 72'd0);
        end

        // Full frame with ack tied high, table-driven.
        b4.calc_ack = 1'b1;
        fd_before   = fd4;
        pops_before = pops4;
        start4();
        check("ready_after_start", 72'(b4.pixel_ready), 72'd1);
        check("busy_after_start",  72'(b4.busy), 72'd1);
        for (int i = 0; i < 16; i++) begin
            send4(vec[i].r, vec[i].c, waited);
            check($sformatf("thru_wait_%0d", i), 72'(waited), 72'd0);
            check($sformatf("start_%0d", i), 72'(b4.start_calculations), 72'(vec[i].exp_start));
            check($sformatf("busy_%0d", i),  72'(b4.busy), 72'd1);
            if (vec[i].exp_start) begin
                check($sformatf("row_%0d", i), 72'(b4.win_row), 72'(vec[i].exp_row));
                check($sformatf("col_%0d", i), 72'(b4.win_col), 72'(vec[i].exp_col));
            end
            if (vec[i].r == 2 && vec[i].c == 2) begin
                check("first_window", dut_win4(), first_win);
                check("first_gx", 72'(gx_of(dut_win4())), 72'd8);
            end
        end
        @(posedge clk);
        #1;
        check("frame_done_high", 72'(b4.frame_done), 72'd1);
        check("busy_after_ack",  72'(b4.busy), 72'd0);
        check("start_after_ack", 72'(b4.start_calculations), 72'd0);
        @(posedge clk);
        #1;
        check("frame_done_one_cycle", 72'(b4.frame_done), 72'd0);
        check("window_count_frame1", 72'(pops4 - pops_before), 72'd4);
        check("done_pulses_frame1",  72'(fd4 - fd_before), 72'd1);
        check("queue_empty_frame1",  72'(q4.size()), 72'd0);

        // Backpressure after the first window.
        start4();
        for (int i = 0; i < 11; i++) send4(i / 4, i % 4, waited);
        b4.calc_ack    = 1'b0;
        b4.pixel_in    = p4(2, 3);
        b4.pixel_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_ready_%0d", k),  72'(b4.pixel_ready), 72'd0);
            check($sformatf("stall_start_%0d", k),  72'(b4.start_calculations), 72'd1);
            check($sformatf("stall_window_%0d", k), dut_win4(), first_win);
            check($sformatf("stall_row_%0d", k),    72'(b4.win_row), 72'd1);
            check($sformatf("stall_col_%0d", k),    72'(b4.win_col), 72'd1);
        end
        @(posedge clk);
        #1;
        b4.calc_ack = 1'b1;
        send4(2, 3, waited);
        b4.calc_ack = 1'b0;
        check("release_same_cycle", 72'(waited), 72'd0);
        check("second_window", dut_win4(), second_win);
        check("second_row", 72'(b4.win_row), 72'd1);
        check("second_col", 72'(b4.win_col), 72'd2);
        check("second_start", 72'(b4.start_calculations), 72'd1);

        // Asynchronous reset in the middle of a cycle while a window is held.
        fd_before = fd4;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero4("async_rst");
        q4.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        b4.calc_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("ready_after_async_rst", 72'(b4.pixel_ready), 72'd0);

        // Ignored frame_start mid-stream, then reset at pixel 9.
        start4();
        for (int i = 0; i < 9; i++) begin
            if (i == 7) b4.frame_start = 1'b1;
            send4(i / 4, i % 4, waited);
            b4.frame_start = 1'b0;
        end
        b4.pixel_in    = p4(2, 1);
        b4.pixel_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", 72'(b4.pixel_ready), 72'd0);
        check("abort_busy",  72'(b4.busy), 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        b4.pixel_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 72'(fd4 - fd_before), 72'd0);

        // Fresh frame after the abort; frame_start at pixel 7 again ignored.
        pops_before = pops4;
        start4();
        for (int i = 0; i < 16; i++) begin
            if (i == 7) b4.frame_start = 1'b1;
            send4(i / 4, i % 4, waited);
            b4.frame_start = 1'b0;
            if (i == 10) check("restart_first_window", dut_win4(), first_win);
        end
        @(posedge clk);
        #1;
        check("restart_frame_done", 72'(b4.frame_done), 72'd1);
        @(posedge clk);
        #1;
        check("restart_window_count", 72'(pops4 - pops_before), 72'd4);
        check("restart_done_pulses",  72'(fd4 - fd_before), 72'd1);
        check("restart_queue_empty",  72'(q4.size()), 72'd0);

        // 8x8 random image with random valid and ack gaps.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img8[r][c] = 8'($urandom);
        pops_before = pops8;
        b8.frame_start = 1'b1;
        @(posedge clk);
        #1;
        b8.frame_start = 1'b0;
        fork
            begin
                while (!done8) begin
                    b8.calc_ack = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                b8.calc_ack = 1'b0;
            end
            begin
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        send8(r, c);
                    end
                end
                n = 0;
                while (b8.frame_done !== 1'b1 && n < 500) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("big_frame_done", 72'(b8.frame_done), 72'd1);
                done8 = 1'b1;
            end
        join
        check("big_window_count", 72'(pops8 - pops_before), 72'd36);
        check("big_queue_empty",  72'(q8.size()), 72'd0);
        check("big_busy_idle",    72'(b8.busy), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
